// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone classic slave UART transmitter (8N1) with TX FIFO, status and divisor registers.
module wb_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        tx_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic          ovf_q, ovf_d, ack_q, ack_d, err_q, err_d, tx_q, tx_d;
  logic [15:0]   div_q, div_d, bdiv_q, bdiv_d, cnt_q, cnt_d, div_w;
  logic [31:0]   dat_q, dat_d, status;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_q, bit_d;
  state_t        st_q, st_d;
  logic          req, full, empty, push, pop;
  logic [1:0]    reg_sel;
  logic          unused;
  assign unused  = ^{adr_i[31:4], adr_i[1:0], sel_i[3:2], dat_i[31:16]};
  assign reg_sel = adr_i[3:2];
  assign req     = cyc_i & stb_i & ~ack_q & ~err_q;
  assign full    = lvl_q == (AW+1)'(FIFO_DEPTH);
  assign empty   = lvl_q == '0;
  assign pop     = (st_q == IDLE) & ~empty;
  assign status  = {16'b0, 8'(lvl_q), 4'b0, ovf_q, st_q != IDLE, empty, full};
  assign div_w   = {sel_i[1] ? dat_i[15:8] : div_q[15:8], sel_i[0] ? dat_i[7:0] : div_q[7:0]};
  always_comb begin
    ack_d = req & (reg_sel != 2'd3);
    err_d = req & (reg_sel == 2'd3);
    push  = ack_d & we_i & (reg_sel == 2'd0) & sel_i[0];
    wr_d  = wr_q + AW'(push & ~full);
    rd_d  = rd_q + AW'(pop);
    lvl_d = lvl_q + (AW+1)'(push & ~full) - (AW+1)'(pop);
    // Full is judged on pre-edge level, so a simultaneous pop cannot rescue the push
    ovf_d = (push & full) | (ovf_q & ~(ack_d & we_i & (reg_sel == 2'd1) & sel_i[0] & dat_i[3]));
    div_d = (ack_d & we_i & (reg_sel == 2'd2)) ? ((div_w == 16'd0) ? 16'd1 : div_w) : div_q;
    dat_d = (ack_d & ~we_i) ? ((reg_sel == 2'd1) ? status : (reg_sel == 2'd2) ? {16'b0, div_q} : 32'b0) : 32'b0;
  end
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    bit_d  = bit_q;
    bdiv_d = bdiv_q;
    tx_d   = tx_q;
    case (st_q)
      IDLE: if (!empty) begin
        st_d   = START;
        sh_d   = mem_q[rd_q];
        bdiv_d = div_q;
        cnt_d  = div_q - 16'd1;
        tx_d   = 1'b0;
      end
      START: if (cnt_q == 16'd0) begin
        st_d  = DATA;
        tx_d  = sh_q[0];
        cnt_d = bdiv_q - 16'd1;
        bit_d = 3'd0;
      end else cnt_d = cnt_q - 16'd1;
      DATA: if (cnt_q == 16'd0) begin
        cnt_d = bdiv_q - 16'd1;
        st_d  = (bit_q == 3'd7) ? STOP : DATA;
        tx_d  = (bit_q == 3'd7) ? 1'b1 : sh_q[1];
        sh_d  = sh_q >> 1;
        bit_d = bit_q + 3'd1;
      end else cnt_d = cnt_q - 16'd1;
      STOP: if (cnt_q == 16'd0) st_d = IDLE;
            else cnt_d = cnt_q - 16'd1;
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      dat_q  <= '0;
      div_q  <= 16'(CLKS_PER_BIT);
      bdiv_q <= 16'(CLKS_PER_BIT);
      cnt_q  <= '0;
      sh_q   <= '0;
      bit_q  <= '0;
      st_q   <= IDLE;
      tx_q   <= 1'b1;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      ovf_q  <= ovf_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
      dat_q  <= dat_d;
      div_q  <= div_d;
      bdiv_q <= bdiv_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      bit_q  <= bit_d;
      st_q   <= st_d;
      tx_q   <= tx_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push & ~full) mem_q[wr_q] <= dat_i[7:0];
  end
  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;
  assign rty_o = 1'b0;
  assign tx_o  = tx_q;
endmodule

// File: doc/wb_uart_tx.md
Name: wb_uart_tx

Overview:
- Wishbone B4 classic slave UART transmitter, on the bus directly downstream of the CPU's data/instruction master port.
- The CPU writes bytes into a small TX FIFO.
- A bit-timing FSM serialises each byte as 8N1, LSB first, on tx_o.
- Status and baud divisor registers are readable and writable over the same bus.

Parameters:
- CLKS_PER_BIT, 16, reset value of the divisor register (clock cycles per serial bit).
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..128.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset
- cyc_i  input  1  Wishbone cycle
- stb_i  input  1  Wishbone strobe
- we_i  input  1  write enable
- adr_i  input  32  byte address; only [3:2] decoded
- sel_i  input  4  byte selects
- dat_i  input  32  write data
- dat_o  output  32  read data
- ack_o  output  1  transfer acknowledge
- err_o  output  1  error response (unmapped address)
- rty_o  output  1  tied 0
- tx_o  output  1  serial output, idle high

Clocking and reset:
- Single clock clk_i; rst_i is synchronous, active-high.

Behaviour:
- Reset values:
  - ack_o=0, err_o=0, rty_o=0, dat_o=0, tx_o=1.
  - FIFO empty, overflow flag 0, divisor=CLKS_PER_BIT, FSM IDLE.
  - Reset mid-frame aborts the frame: tx_o=1 from the first edge with rst_i high, and queued bytes are discarded.
- Register map (adr_i[3:2]):
  - 0 DATA:
    - Write with sel_i[0]=1 pushes dat_i[7:0].
    - Write with sel_i[0]=0 is acked and has no effect.
    - Read returns 0.
  - 1 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[15:8] FIFO level; other bits 0.
  - 1 STATUS (write): writing 1 to bit3 with sel_i[0] clears overflow; other bits ignored.
  - 2 DIVISOR: bits[15:0].
    - Writes honour sel_i[0], sel_i[1] per byte.
    - A written value of 0 is stored as 1.
    - Read returns the value zero-extended.
  - 3: unmapped. Returns err_o instead of ack_o; no side effects; dat_o=0.
- Handshake:
  - Registered response. On the edge where cyc_i&stb_i is high and neither ack_o nor err_o is high, exactly one of ack_o/err_o is set for one cycle.
  - Next edge clears it, so a master holding stb gets exactly one response per access, one cycle of latency.
  - All side effects (push, divisor write, overflow clear) happen on the same edge that sets ack_o.
  - dat_o is valid while ack_o=1.
  - Nothing happens without cyc_i.
- FIFO:
  - Push to a full FIFO drops the byte, still acks, and sets overflow.
  - Full is evaluated on pre-edge state: a push and an FSM pop on the same edge with the FIFO full still drops the push.
  - Push and pop on the same edge with the FIFO not full: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; level counter has log2(FIFO_DEPTH)+1 bits.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: if FIFO non-empty, pop on this edge, latch byte and divisor, enter START; tx_o<=0.
  - Bit counter counts divisor-1 down to 0. Every bit, including start and stop, lasts exactly the latched divisor in cycles.
  - START -> DATA after one bit time, tx_o=bit0.
  - DATA shifts bits 0..7 LSB first, then -> STOP with tx_o=1.
  - STOP -> IDLE after one bit time.
  - Back-to-back bytes: the IDLE cycle is included. Frame period = 10*divisor+1 cycles.
  - A DIVISOR write mid-frame takes effect at the next frame.
- Latency: write ack on edge E0 (FIFO empty, IDLE) -> pop on E1, tx_o low from E1.

Test Plan:
- Reset, then read STATUS (adr 0x4) -> ack after 1 cycle, dat_o=0x00000002; tx_o=1.
- DIVISOR=4, write 0xA5 to 0x0 -> tx_o low 1 cycle after ack. Sampled mid-bit every 4 cycles: 0,1,0,1,0,0,1,0,1,1. busy=1 during the frame, then STATUS=0x2.
- DIVISOR=4, write FIFO_DEPTH+2 bytes back-to-back while tx busy -> STATUS shows full, overflow bit3=1.
  - Exactly FIFO_DEPTH+1 bytes are transmitted: one already popped, plus FIFO_DEPTH.
  - Each frame is 41 cycles apart.
  - Writing 0x8 to STATUS clears bit3.
- Access adr 0xC read and write -> err_o pulses 1 cycle, ack_o=0, no state change. Holding stb for 3 cycles yields a single response.
- Write DIVISOR=0 -> reads back 1. Write 0x1234 with sel=0b0001 -> reads 0x0034.
- Assert rst_i mid-DATA bit -> tx_o=1 after the edge; STATUS=0x2; divisor reads back CLKS_PER_BIT.
